// File: rtl/memshare_l1pard_sched_pkg.sv
// Shared types, default geometry and helpers for the Type-0 L1PA read scheduler.
package memshare_l1pard_sched_pkg;

    localparam int unsigned DEF_ADDR_BITWIDTH = 5;
    localparam int unsigned DEF_PAGE_NUM      = 32;
    localparam int unsigned DEF_REG_BITWIDTH  = 7;
    localparam int unsigned DEF_RD_CYCLE      = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } rdsched_state_t;

    // Requested run length limited to the number of physical pages.
    function automatic int unsigned clamp_page_cnt(input int unsigned cnt,
                                                   input int unsigned page_num);
        return (cnt > page_num) ? page_num : cnt;
    endfunction

endpackage

// File: rtl/memshare_l1pard_sched_vpipe.sv
// Valid-strobe delay line matching the regfile read latency.
module memshare_l1pard_sched_vpipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic empty_c
);

    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;

    generate
        if (DEPTH == 1) begin : g_single
            assign stage_d = din;
        end else begin : g_multi
            assign stage_d = {stage_q[DEPTH-2:0], din};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout    = stage_q[DEPTH-1];
    // Empty once this cycle's shift lands, so the drain exits without an idle bubble.
    assign empty_c = ~|stage_d;

endmodule

// File: rtl/memshare_l1pard_sched.sv
// Type-0 L1PA regfile read scheduler: issues a run of page reads and gates host config writes.
module memshare_l1pard_sched
    import memshare_l1pard_sched_pkg::*;
#(
    parameter int unsigned TYPE0_ADDR_BITWIDTH = DEF_ADDR_BITWIDTH,
    parameter int unsigned TYPE0_PAGE_NUM      = DEF_PAGE_NUM,
    parameter int unsigned TYPE0_REG_BITWIDTH  = DEF_REG_BITWIDTH,
    parameter int unsigned REGFILE_RD_CYCLE    = DEF_RD_CYCLE
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [TYPE0_ADDR_BITWIDTH-1:0] page_base,
    input  logic [TYPE0_ADDR_BITWIDTH:0]   page_cnt,
    input  logic                           stall,
    input  logic                           cfg_valid,
    input  logic [TYPE0_ADDR_BITWIDTH-1:0] cfg_waddr,
    input  logic [TYPE0_REG_BITWIDTH-1:0]  cfg_wdata,
    output logic                           cfg_ready,
    output logic [TYPE0_ADDR_BITWIDTH-1:0] reg_type0_raddr,
    output logic [TYPE0_ADDR_BITWIDTH-1:0] reg_type0_waddr_c,
    output logic [TYPE0_REG_BITWIDTH-1:0]  reg_type0_wdata_c,
    output logic                           reg_type0_we_c,
    output logic                           delta_pipe_rst_n,
    output logic                           rd_valid,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned AW = TYPE0_ADDR_BITWIDTH;
    localparam int unsigned CW = TYPE0_ADDR_BITWIDTH + 1;

    rdsched_state_t state_q;
    rdsched_state_t state_d;

    logic [AW-1:0] base_q;
    logic [AW-1:0] raddr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] idx_q;
    logic [CW-1:0] cnt_clamped;
    logic [AW-1:0] raddr_next;
    logic          issue;
    logic          pipe_empty;
    logic          run_accept;
    logic          last_issue;

    assign cnt_clamped = CW'(clamp_page_cnt(32'(page_cnt), TYPE0_PAGE_NUM));
    // Wrap at the page count, which need not be a power of two.
    assign raddr_next  = (raddr_q == AW'(TYPE0_PAGE_NUM - 1)) ? '0 : raddr_q + AW'(1);
    assign run_accept  = (state_q == ST_IDLE) && start && (page_cnt != '0);
    assign last_issue  = (idx_q == cnt_q - CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (page_cnt == '0) ? ST_DONE : ST_INIT;
                end
            end
            ST_INIT: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!stall) begin
                    issue = 1'b1;
                    if (last_issue) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Run context and read address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            raddr_q <= '0;
        end else begin
            if (run_accept) begin
                base_q <= page_base;
                cnt_q  <= cnt_clamped;
                idx_q  <= '0;
            end
            if (state_q == ST_INIT) begin
                raddr_q <= base_q;
            end else if (issue) begin
                raddr_q <= raddr_next;
                idx_q   <= idx_q + CW'(1);
            end
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready        <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b0;
            delta_pipe_rst_n <= 1'b0;
        end else begin
            cfg_ready        <= (state_d == ST_IDLE);
            busy             <= (state_d != ST_IDLE);
            done             <= (state_d == ST_DONE);
            delta_pipe_rst_n <= (state_d != ST_INIT);
        end
    end

    memshare_l1pard_sched_vpipe #(
        .DEPTH (REGFILE_RD_CYCLE)
    ) u_vpipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (issue),
        .dout    (rd_valid),
        .empty_c (pipe_empty)
    );

    assign reg_type0_raddr   = raddr_q;
    assign reg_type0_waddr_c = cfg_waddr;
    assign reg_type0_wdata_c = cfg_wdata;
    assign reg_type0_we_c    = cfg_valid & cfg_ready;

endmodule
